// File: rtl/alu_ft_pkg.sv
// Shared types and constants for the ALU_ft result monitor and its result FIFO.
package alu_ft_pkg;

    // Health state of the monitored ALU; encoding is visible on mon_state.
    typedef enum logic [1:0] {
        StOk      = 2'd0,
        StSuspect = 2'd1,
        StAlarm   = 2'd2
    } mon_state_e;

    // Bit positions inside the 4-bit flag field: {Negative, OverFlow, Carry, Zero}.
    localparam int unsigned FlagZero     = 0;
    localparam int unsigned FlagCarry    = 1;
    localparam int unsigned FlagOverFlow = 2;
    localparam int unsigned FlagNegative = 3;

    // One buffered ALU_ft result: 32 + 4 + 1 = 37 bits.
    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        fault;
    } res_entry_t;

    localparam int unsigned ResEntryW = $bits(res_entry_t);

    // Assemble the flag field in the fixed bit order above.
    function automatic logic [3:0] pack_flags(input logic zero, input logic carry,
                                              input logic overflow, input logic negative);
        logic [3:0] f;
        f               = '0;
        f[FlagZero]     = zero;
        f[FlagCarry]    = carry;
        f[FlagOverFlow] = overflow;
        f[FlagNegative] = negative;
        return f;
    endfunction

endpackage

// File: rtl/alu_ft_res_fifo.sv
// Result FIFO: DEPTH entries, registered output (no fall-through), push on full
// only succeeds when a pop happens in the same cycle; otherwise the entry is dropped.
module alu_ft_res_fifo
    import alu_ft_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  res_entry_t wdata_i,
    input  logic       pop_i,
    output logic       valid_o,
    output res_entry_t rdata_o,
    output logic       drop_o
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Extra MSB distinguishes full from empty when the index bits match.
    localparam int unsigned PtrW  = AddrW + 1;

    res_entry_t        mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic              empty;
    logic              full;
    logic              pop_ok;
    logic              push_ok;

    // Occupancy decode and handshake qualification.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                  (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
        pop_ok  = pop_i && !empty;
        push_ok = push_i && (!full || pop_ok);
        drop_o  = push_i && full && !pop_ok;
        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    end

    // Head is only meaningful while valid; drive zeros otherwise.
    always_comb begin
        valid_o = !empty;
        rdata_o = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_ft_result_monitor.sv
// Buffers ALU_ft results and tracks fault health: OK / SUSPECT / ALARM state machine,
// saturating fault and drop counters, sticky overflow flag.
module alu_ft_result_monitor
    import alu_ft_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FAULT_THRESH = 3,
    parameter int unsigned CLEAN_RUN    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [31:0] Result,
    input  logic        Zero,
    input  logic        Carry,
    input  logic        OverFlow,
    input  logic        Negative,
    input  logic        fault_detected_out,
    input  logic        clear_alarm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic        out_fault,
    output logic [15:0] fault_count,
    output logic [7:0]  drop_count,
    output logic        overflow_sticky,
    output logic        alarm,
    output logic [1:0]  mon_state
);

    localparam int unsigned CfW = $clog2(FAULT_THRESH + 1);
    localparam int unsigned ClW = $clog2(CLEAN_RUN + 1);
    localparam logic [CfW-1:0] FaultThreshC = CfW'(FAULT_THRESH);
    localparam logic [ClW-1:0] CleanRunC    = ClW'(CLEAN_RUN);

    res_entry_t       wentry;
    res_entry_t       head;
    logic             fifo_valid;
    logic             fifo_drop;
    logic             pop;

    mon_state_e       state_q, state_d;
    logic [CfW-1:0]   consec_q, consec_d;
    logic [ClW-1:0]   clean_q, clean_d;
    logic [15:0]      fault_cnt_q, fault_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             sticky_q, sticky_d;
    logic [CfW-1:0]   consec_inc;
    logic [ClW-1:0]   clean_inc;

    // Pack the incoming result into a FIFO entry.
    always_comb begin
        wentry        = '0;
        wentry.result = Result;
        wentry.flags  = pack_flags(Zero, Carry, OverFlow, Negative);
        wentry.fault  = fault_detected_out;
    end

    assign pop = fifo_valid & out_ready;

    alu_ft_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (res_valid),
        .wdata_i (wentry),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .rdata_o (head),
        .drop_o  (fifo_drop)
    );

    // Head of FIFO drives the consumer interface.
    always_comb begin
        out_valid  = fifo_valid;
        out_result = head.result;
        out_flags  = head.flags;
        out_fault  = head.fault;
    end

    // Counters and health state machine next-state; res_valid=0 leaves health untouched.
    always_comb begin
        state_d     = state_q;
        consec_d    = consec_q;
        clean_d     = clean_q;
        fault_cnt_d = fault_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        sticky_d    = sticky_q;
        consec_inc  = consec_q + CfW'(1);
        clean_inc   = clean_q + ClW'(1);

        // Every faulty result counts, whatever happens to it in the FIFO.
        if (res_valid && fault_detected_out && (fault_cnt_q != 16'hFFFF)) begin
            fault_cnt_d = fault_cnt_q + 16'd1;
        end

        if (fifo_drop) begin
            sticky_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        unique case (state_q)
            StOk: begin
                if (res_valid && fault_detected_out) begin
                    consec_d = CfW'(1);
                    clean_d  = '0;
                    state_d  = (CfW'(1) == FaultThreshC) ? StAlarm : StSuspect;
                end
            end
            StSuspect: begin
                if (res_valid) begin
                    if (fault_detected_out) begin
                        consec_d = consec_inc;
                        clean_d  = '0;
                        if (consec_inc == FaultThreshC) begin
                            state_d = StAlarm;
                        end
                    end else begin
                        consec_d = '0;
                        clean_d  = clean_inc;
                        if (clean_inc == CleanRunC) begin
                            state_d = StOk;
                        end
                    end
                end
            end
            StAlarm: begin
                // A coincident faulty result is not carried into the new OK period.
                if (clear_alarm) begin
                    state_d  = StOk;
                    consec_d = '0;
                    clean_d  = '0;
                end
            end
            default: begin
                state_d  = StOk;
                consec_d = '0;
                clean_d  = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StOk;
            consec_q    <= '0;
            clean_q     <= '0;
            fault_cnt_q <= '0;
            drop_cnt_q  <= '0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            consec_q    <= consec_d;
            clean_q     <= clean_d;
            fault_cnt_q <= fault_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            sticky_q    <= sticky_d;
        end
    end

    // Status outputs.
    always_comb begin
        fault_count     = fault_cnt_q;
        drop_count      = drop_cnt_q;
        overflow_sticky = sticky_q;
        alarm           = (state_q == StAlarm);
        mon_state       = state_q;
    end

endmodule
